// File: rtl/add_round_key_unit.sv
// AddRoundKey stage: round-key bank feeding a one-entry registered output with valid/ready.
// Optional feature macro ARK_ERR_COUNT_EN adds a saturating err_count output.
module add_round_key_unit #(
    parameter int BLOCK_W  = 128,
    parameter int NUM_KEYS = 11,
    parameter int IDX_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_we,
    input  logic [IDX_W-1:0]   key_waddr,
    input  logic [BLOCK_W-1:0] key_wdata,
    input  logic               key_clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_state,
    input  logic [IDX_W-1:0]   in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_state,
    output logic [IDX_W-1:0]   out_round,
    output logic               out_err
`ifdef ARK_ERR_COUNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [BLOCK_W-1:0]   key_mem_r [NUM_KEYS];
    logic [NUM_KEYS-1:0]  key_vld_r;
    logic [BLOCK_W-1:0]   sel_key_s;
    logic                 sel_hit_s;
    logic                 accept_s;
    logic [BLOCK_W-1:0]   res_state_s;
    logic                 res_err_s;
    logic [BLOCK_W-1:0]   out_state_r;
    logic [IDX_W-1:0]     out_round_r;
    logic                 out_err_r;

    assign out_valid = (state_r == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_state = out_state_r;
    assign out_round = out_round_r;
    assign out_err   = out_err_r;

    // Key slot data; not reset, only the valid bits gate its use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_we && (key_waddr == i[IDX_W-1:0])) begin
                key_mem_r[i] <= key_wdata;
            end
        end
    end

    // Per-slot valid bits; clear dominates a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_vld_r <= '0;
        end else if (key_clear) begin
            key_vld_r <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_we && (key_waddr == i[IDX_W-1:0])) begin
                    key_vld_r[i] <= 1'b1;
                end
            end
        end
    end

    // One-hot key select; a miss leaves sel_key_s zero so the state passes through unchanged.
    always_comb begin
        sel_key_s = '0;
        sel_hit_s = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            sel_key_s = sel_key_s | ({BLOCK_W{(in_round == i[IDX_W-1:0]) && key_vld_r[i]}} & key_mem_r[i]);
            sel_hit_s = sel_hit_s | ((in_round == i[IDX_W-1:0]) && key_vld_r[i]);
        end
        res_state_s = in_state ^ sel_key_s;
        res_err_s   = !sel_hit_s;
    end

    // Output-register next state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_s = FULL;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                if (out_ready && !accept_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = FULL;
                end
            end
            default: state_s = EMPTY;
        endcase
    end

    // Output register; loads only on accept so a stalled result holds stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            out_state_r <= '0;
            out_round_r <= '0;
            out_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                out_state_r <= res_state_s;
                out_round_r <= in_round;
                out_err_r   <= res_err_s;
            end
        end
    end

`ifdef ARK_ERR_COUNT_EN
    logic [15:0] err_cnt_r;

    // Saturating count of accepted requests that will flag out_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= 16'd0;
        end else if (key_clear) begin
            err_cnt_r <= 16'd0;
        end else if (accept_s && res_err_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_add_round_key_unit.sv
// Randomised scoreboard bench for add_round_key_unit with FIPS-197 directed vectors.
module tb_add_round_key_unit;
    localparam int BW = 128;
    localparam int NK = 11;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset, key_we, key_clear, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [IW-1:0] key_waddr, in_round, out_round;
    logic [BW-1:0] key_wdata, in_state, out_state;
`ifdef ARK_ERR_COUNT_EN
    logic [15:0]   err_count;
`endif

    always #5 clk = ~clk;

    add_round_key_unit #(.BLOCK_W(BW), .NUM_KEYS(NK), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata), .key_clear(key_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_err(out_err)
`ifdef ARK_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    typedef struct packed {
        logic [BW-1:0] st;
        logic [IW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic [BW-1:0] ref_key [16];
    logic          ref_vld [16];
    int            ref_cnt;
    int            checks = 0;
    int            errors = 0;
    logic          hold_v = 1'b0;
    exp_t          held;

    localparam logic [BW-1:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [BW-1:0] K1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [BW-1:0] K2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [BW-1:0] KN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BW-1:0] X1 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [BW-1:0] X2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    task automatic chk(input string name, input logic ok, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [BW-1:0] st, input logic [IW-1:0] rd);
        exp_t e;
        e.rd = rd;
        if (rd < NK && ref_vld[rd]) begin
            e.st  = st ^ ref_key[rd];
            e.err = 1'b0;
        end else begin
            e.st  = st;
            e.err = 1'b1;
        end
        return e;
    endfunction

    // One clock of stimulus; the model updates keys after computing the result (read-before-write).
    task automatic cycle(input logic v, input logic [BW-1:0] st, input logic [IW-1:0] rd,
                         input logic kw, input logic [IW-1:0] ka, input logic [BW-1:0] kd,
                         input logic kc, input logic ordy, input logic lit, input logic [BW-1:0] lit_st);
        exp_t e;
        logic acc;
        @(posedge clk);
        #2;
`ifdef ARK_ERR_COUNT_EN
        chk("err_count", err_count == ref_cnt[15:0], {112'd0, err_count}, {112'd0, ref_cnt[15:0]});
`endif
        in_valid  = v;
        in_state  = st;
        in_round  = rd;
        key_we    = kw;
        key_waddr = ka;
        key_wdata = kd;
        key_clear = kc;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        e = model(st, rd);
        if (lit) e.st = lit_st;
        if (acc) sb_q.push_back(e);
        if (kc) ref_cnt = 0;
        else if (acc && e.err && ref_cnt < 65535) ref_cnt++;
        if (kc) begin
            for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
        end else if (kw && ka < NK) begin
            ref_key[ka] = kd;
            ref_vld[ka] = 1'b1;
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ordy, 1'b0, '0);
    endtask

    task automatic wkey(input logic [IW-1:0] ka, input logic [BW-1:0] kd);
        cycle(1'b0, '0, '0, 1'b1, ka, kd, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic send(input logic [BW-1:0] st, input logic [IW-1:0] rd, input logic ordy);
        cycle(1'b1, st, rd, 1'b0, '0, '0, 1'b0, ordy, 1'b0, '0);
    endtask

    task automatic sendl(input logic [BW-1:0] st, input logic [IW-1:0] rd, input logic [BW-1:0] exp_st);
        cycle(1'b1, st, rd, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, exp_st);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        reset = 1'b1; in_valid = 1'b0; key_we = 1'b0; key_clear = 1'b0; out_ready = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
        ref_cnt = 0;
        repeat (n - 1) @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid == 1'b0, {127'd0, out_valid}, '0);
        chk("rst_out_state", out_state == '0, out_state, '0);
        chk("rst_out_round", out_round == '0, {124'd0, out_round}, '0);
        chk("rst_out_err", out_err == 1'b0, {127'd0, out_err}, '0);
    endtask

    // Monitor: compares each transferred result against the scoreboard and checks stall stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_stable", out_valid && out_state == held.st && out_round == held.rd && out_err == held.err,
                        out_state, held.st);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: actual %h required no output", out_state);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_state", out_state == e.st, out_state, e.st);
                        chk("out_round", out_round == e.rd, {124'd0, out_round}, {124'd0, e.rd});
                        chk("out_err", out_err == e.err, {127'd0, out_err}, {127'd0, e.err});
                    end
                    hold_v = 1'b0;
                end else if (out_valid) begin
                    hold_v   = 1'b1;
                    held.st  = out_state;
                    held.rd  = out_round;
                    held.err = out_err;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        int t;
        logic v, kw, kc, ordy;
        logic [IW-1:0] rd, ka;
        reset = 1'b1; key_we = 1'b0; key_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key_waddr = '0; key_wdata = '0; in_state = '0; in_round = '0;
        do_reset(2);
        chk("rst_in_ready", in_ready == 1'b1, {127'd0, in_ready}, 128'd1);

        // FIPS-197 round 0 and rounds 1/2 back-to-back
        wkey(4'd0, K0);
        sendl(128'h3243f6a8885a308d313198a2e0370734, 4'd0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        wkey(4'd1, K1);
        wkey(4'd2, K2);
        sendl(128'h046681e5e0cb199a48f8d37a2806264c, 4'd1, 128'ha49c7ff2689f352b6b5bea43026a5049);
        sendl(128'h584dcaf11b4b5aacdbe7caa81b6bb0e5, 4'd2, 128'haa8f5f0361dde3ef82d24ad26832469a);
        idle(1'b1);

        // Backpressure: five stalled cycles then drain
        send(X1, 4'd1, 1'b0);
        repeat (5) begin
            send(X2, 4'd2, 1'b0);
            chk("stall_in_ready", in_ready == 1'b0, {127'd0, in_ready}, '0);
        end
        idle(1'b1);
        chk("drain_in_ready", in_ready == 1'b1, {127'd0, in_ready}, 128'd1);
        idle(1'b1);

        // Out-of-range round and unwritten slot
        send(X1, 4'd12, 1'b1);
        send(X2, 4'd5, 1'b1);
        idle(1'b1);
`ifdef ARK_ERR_COUNT_EN
        #3;
        chk("err_count_two", err_count == 16'd2, {112'd0, err_count}, 128'd2);
`endif

        // Key rewrite on the accept cycle: old key applies, next block sees the new key
        cycle(1'b1, X1, 4'd0, 1'b1, 4'd0, KN, 1'b0, 1'b1, 1'b1, X1 ^ K0);
        sendl(X2, 4'd0, X2 ^ KN);
        idle(1'b1);

        // Clear beats a simultaneous write
        cycle(1'b0, '0, '0, 1'b1, 4'd3, K1, 1'b1, 1'b1, 1'b0, '0);
        send(X1, 4'd3, 1'b1);
        idle(1'b1);

        // Reset while FULL drops the held result and invalidates all keys
        wkey(4'd0, K0);
        send(X1, 4'd0, 1'b0);
        idle(1'b0);
        do_reset(1);
        send(X2, 4'd0, 1'b1);
        idle(1'b1);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 15)) : IW'($urandom_range(0, 10));
            kw   = ($urandom_range(0, 2) == 0);
            ka   = ($urandom_range(0, 4) == 0) ? IW'($urandom_range(0, 15)) : IW'($urandom_range(0, 10));
            kc   = ($urandom_range(0, 40) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(v, {$urandom, $urandom, $urandom, $urandom}, rd, kw, ka,
                  {$urandom, $urandom, $urandom, $urandom}, kc, ordy, 1'b0, '0);
        end

        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            idle(1'b1);
            t++;
        end
        idle(1'b1);
        idle(1'b1);
        chk("drain_timeout", sb_q.size() == 0, 128'(sb_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
